// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that tracks the fixed memory latency; holds at zero.
module lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported I/D memory between Fetch and Memory stages,
// tracks the fixed-latency access and produces the pipeline stalls.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InstrReqF,
  input  logic [XLEN-1:0] PCF,
  input  logic            KillF,
  input  logic            DataReqM,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [3:0]      ByteEnM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrValidF,
  output logic [XLEN-1:0] ReadDataM,
  output logic            DataValidM,
  output logic            StallF,
  output logic            StallM,
  output logic [1:0]      dbg_state
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          drop_q, drop_d;
  logic          cnt_load;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  lat_counter #(.W(CW)) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Handshake: requesters hold their request and operands stable while the
  // matching stall is high; a one-cycle valid pulse marks completion, after
  // which the requester may change or drop its request.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    cnt_load    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = 4'h0;
    InstrF      = '0;
    InstrValidF = 1'b0;
    ReadDataM   = '0;
    DataValidM  = 1'b0;
    StallM      = 1'b0;
    StallF      = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (DataReqM) begin
            mem_req   = 1'b1;
            mem_we    = MemWriteM;
            mem_addr  = ALUResultM;
            mem_wdata = WriteDataM;
            mem_be    = MemWriteM ? ByteEnM : BE_FULL;
            cnt_load  = 1'b1;
            state_d   = BUSY_D;
          end else if (InstrReqF && !KillF) begin
            mem_req  = 1'b1;
            mem_addr = PCF;
            mem_be   = BE_FULL;
            cnt_load = 1'b1;
            drop_d   = 1'b0;
            state_d  = BUSY_I;
          end
        end
        BUSY_I: begin
          if (cnt_zero) begin
            InstrF      = mem_rdata;
            InstrValidF = ~(drop_q | KillF);
            drop_d      = 1'b0;
            state_d     = IDLE;
          end else if (KillF) begin
            drop_d = 1'b1;
          end
        end
        BUSY_D: begin
          if (cnt_zero) begin
            ReadDataM  = mem_rdata;
            DataValidM = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      StallM = DataReqM & ~DataValidM;
      StallF = StallM | (InstrReqF & ~InstrValidF & ~KillF);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: MEM_LAT=2 instance for the main flows and a
// MEM_LAT=1 instance for back-to-back loads.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance signals
  logic        instr_req, kill, data_req, mem_write;
  logic [31:0] pcf, alu_result, write_data, mem_rdata;
  logic [3:0]  byte_en;
  logic        mem_req, mem_we, instr_valid, data_valid, stall_f, stall_m;
  logic [31:0] mem_addr, mem_wdata, instr_f, read_data;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  // MEM_LAT=1 instance signals
  logic        l1_data_req;
  logic [31:0] l1_alu_result, l1_mem_rdata;
  logic        l1_mem_req, l1_mem_we, l1_instr_valid, l1_data_valid, l1_stall_f, l1_stall_m;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_instr_f, l1_read_data;
  logic [3:0]  l1_mem_be;
  logic [1:0]  l1_dbg_state;

  mem_port_arbiter #(.MEM_LAT(2), .XLEN(32)) u_dut (
    .clk(clk), .reset(reset), .InstrReqF(instr_req), .PCF(pcf), .KillF(kill),
    .DataReqM(data_req), .MemWriteM(mem_write), .ALUResultM(alu_result),
    .WriteDataM(write_data), .ByteEnM(byte_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .InstrF(instr_f), .InstrValidF(instr_valid), .ReadDataM(read_data),
    .DataValidM(data_valid), .StallF(stall_f), .StallM(stall_m), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.MEM_LAT(1), .XLEN(32)) u_dut1 (
    .clk(clk), .reset(reset), .InstrReqF(1'b0), .PCF(32'h0), .KillF(1'b0),
    .DataReqM(l1_data_req), .MemWriteM(1'b0), .ALUResultM(l1_alu_result),
    .WriteDataM(32'h0), .ByteEnM(4'h0), .mem_req(l1_mem_req), .mem_we(l1_mem_we),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_be(l1_mem_be),
    .mem_rdata(l1_mem_rdata), .InstrF(l1_instr_f), .InstrValidF(l1_instr_valid),
    .ReadDataM(l1_read_data), .DataValidM(l1_data_valid), .StallF(l1_stall_f),
    .StallM(l1_stall_m), .dbg_state(l1_dbg_state)
  );

  // Memory models: word i preloaded with 0x1000_0000+i, word 4 holds an ADDI.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pa [2];
  logic [31:0] pb;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h1000_0000 + i;
      mem_b[i] = 32'h1000_0000 + i;
    end
    mem_a[4] = 32'h0051_0093;
    pa[0] = 32'h0;
    pa[1] = 32'h0;
    pb    = 32'h0;
  end

  always @(posedge clk) begin
    pa[1] <= pa[0];
    pa[0] <= (mem_req && !mem_we) ? mem_a[mem_addr[9:2]] : 32'h0;
    if (mem_req && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_a[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    pb <= (l1_mem_req && !l1_mem_we) ? mem_b[l1_mem_addr[9:2]] : 32'h0;
  end

  assign mem_rdata    = pa[1];
  assign l1_mem_rdata = pb;

  // Scoreboard: {2'b01,instr} for fetches, {2'b10,data} for data accesses.
  logic [33:0] exp_q[$];
  logic [33:0] exp1_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid || data_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {instr_valid, data_valid, 32'h0}, 34'h0);
      end else begin
        check("resp", instr_valid ? {2'b01, instr_f} : {2'b10, read_data}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (l1_instr_valid || l1_data_valid) begin
      if (exp1_q.size() == 0) begin
        check("l1_spurious_valid", {l1_instr_valid, l1_data_valid, 32'h0}, 34'h0);
      end else begin
        check("l1_resp", l1_instr_valid ? {2'b01, l1_instr_f} : {2'b10, l1_read_data},
              exp1_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    instr_req = 0; kill = 0; data_req = 0; mem_write = 0;
    pcf = 0; alu_result = 0; write_data = 0; byte_en = 0;
    l1_data_req = 0; l1_alu_result = 0;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_stalls", {stall_f, stall_m}, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // fetch only
    next_cycle(); instr_req = 1; pcf = 32'h10;
    exp_q.push_back({2'b01, 32'h0051_0093});
    mid();
    check("f_req", mem_req, 1); check("f_addr", mem_addr, 32'h10);
    check("f_be", mem_be, 4'hF); check("f_we", mem_we, 0); check("f_stall0", stall_f, 1);
    next_cycle(); mid();
    check("f_stall1", stall_f, 1); check("f_req1", mem_req, 0);
    next_cycle(); mid();
    check("f_valid2", instr_valid, 1); check("f_stall2", stall_f, 0);
    next_cycle(); instr_req = 0; mid();
    check("f_idle", dbg_state, 0);

    // load and fetch together: data wins
    next_cycle(); data_req = 1; mem_write = 0; alu_result = 32'h100; instr_req = 1; pcf = 32'h14;
    exp_q.push_back({2'b10, 32'h1000_0040});
    exp_q.push_back({2'b01, 32'h1000_0005});
    mid();
    check("ld_req", mem_req, 1); check("ld_we", mem_we, 0); check("ld_addr", mem_addr, 32'h100);
    check("ld_stall_m0", stall_m, 1); check("ld_stall_f0", stall_f, 1);
    next_cycle(); mid();
    check("ld_stall_m1", stall_m, 1);
    next_cycle(); mid();
    check("ld_valid2", data_valid, 1); check("ld_stall_m2", stall_m, 0); check("ld_stall_f2", stall_f, 1);
    next_cycle(); data_req = 0; mid();
    check("fi_req3", mem_req, 1); check("fi_addr3", mem_addr, 32'h14);
    next_cycle(); mid();
    check("fi_valid4", instr_valid, 0);
    next_cycle(); mid();
    check("fi_valid5", instr_valid, 1);

    // store, then read it back
    next_cycle(); instr_req = 0;
    data_req = 1; mem_write = 1; alu_result = 32'h104; write_data = 32'hDEAD_BEEF; byte_en = 4'b0011;
    exp_q.push_back({2'b10, 32'h0});
    mid();
    check("st_we", mem_we, 1); check("st_be", mem_be, 4'b0011);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF); check("st_addr", mem_addr, 32'h104);
    next_cycle(); mid();
    next_cycle(); mid();
    check("st_valid2", data_valid, 1);
    next_cycle(); mem_write = 0;
    exp_q.push_back({2'b10, 32'h1000_BEEF});
    mid();
    check("rb_req", mem_req, 1); check("rb_we", mem_we, 0); check("rb_be", mem_be, 4'hF);
    next_cycle(); next_cycle(); mid();
    check("rb_valid", data_valid, 1);

    // fetch killed in flight, redirect fetch follows
    next_cycle(); data_req = 0; instr_req = 1; pcf = 32'h20; mid();
    check("k_req0", mem_req, 1);
    next_cycle(); kill = 1; pcf = 32'h40; mid();
    check("k_stall1", stall_f, 0); check("k_req1", mem_req, 0);
    next_cycle(); kill = 0; mid();
    check("k_valid2", instr_valid, 0); check("k_stall2", stall_f, 1);
    next_cycle(); mid();
    exp_q.push_back({2'b01, 32'h1000_0010});
    check("k_state3", dbg_state, 0); check("k_req3", mem_req, 1); check("k_addr3", mem_addr, 32'h40);
    next_cycle(); mid();
    next_cycle(); mid();
    check("k_valid5", instr_valid, 1);

    // async reset during a data access
    next_cycle(); instr_req = 0; data_req = 1; alu_result = 32'h108; mid();
    check("r_req0", mem_req, 1);
    next_cycle();
    check("r_busy", dbg_state, 2); check("r_stall_m", stall_m, 1);
    #1 reset = 1'b1;
    #1;
    check("r_req", mem_req, 0); check("r_stall", {stall_f, stall_m}, 0);
    check("r_outs", {data_valid, instr_valid, mem_we, mem_be}, 0); check("r_state", dbg_state, 0);
    data_req = 0;
    #1 reset = 1'b0;
    next_cycle(); mid();
    check("r_valid2", data_valid, 0); check("r_state2", dbg_state, 0);
    next_cycle(); mid();
    check("r_valid3", data_valid, 0);

    // MEM_LAT=1 back-to-back loads
    next_cycle(); l1_data_req = 1; l1_alu_result = 32'h200;
    exp1_q.push_back({2'b10, 32'h1000_0080});
    mid();
    check("l1_req0", l1_mem_req, 1);
    next_cycle(); mid();
    check("l1_req1", l1_mem_req, 0); check("l1_valid1", l1_data_valid, 1); check("l1_stall1", l1_stall_m, 0);
    next_cycle(); l1_alu_result = 32'h204;
    exp1_q.push_back({2'b10, 32'h1000_0081});
    mid();
    check("l1_req2", l1_mem_req, 1); check("l1_valid2", l1_data_valid, 0); check("l1_stall2", l1_stall_m, 1);
    next_cycle(); mid();
    check("l1_valid3", l1_data_valid, 1);
    next_cycle(); l1_alu_result = 32'h208;
    exp1_q.push_back({2'b10, 32'h1000_0082});
    mid();
    check("l1_req4", l1_mem_req, 1);
    next_cycle(); mid();
    check("l1_valid5", l1_data_valid, 1);
    next_cycle(); l1_data_req = 0;

    repeat (4) next_cycle();
    check("queue_empty", 34'(exp_q.size()), 34'h0);
    check("l1_queue_empty", 34'(exp1_q.size()), 34'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
